tt_um_load_ctrl: RTL
====================

# tt_um_load_ctrl

Sequencing controller for the ternary weight loader and its downstream MAC array. It accepts a load request and steps the loader's slice index across all 16 slices, one slice per valid input beat. It then declares the weights valid and gates activation vectors into the compute path until a reload is requested. It sits between the top-level tile pins and the weight loader, and is the only driver of the loader's `count` input.

## Interface
Parameters:
- `MAX_IN_LEN`, 16: input vector length (ternary weights per slice).
- `MAX_OUT_LEN`, 8: output neuron count.
- `WIDTH`, 2: bits per ternary weight.
- `COUNT_BITS`, `$clog2(MAX_OUT_LEN)+$clog2(WIDTH)` = 4: slice index width.
- `TIMEOUT`, 255: idle-cycle limit during LOAD (used only with the macro below).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `ena`  in  1  tile enable. When low, all state holds and all strobes are 0.
- `load_req`  in  1  level request to (re)load weights.
- `in_valid`  in  1  host beat present on input pins.
- `count`  out  COUNT_BITS  slice index to the loader.
- `load_we`  out  1  slice write strobe to the loader.
- `load_done`  out  1  one-cycle pulse when the last slice is accepted.
- `weights_valid`  out  1  high while in RUN.
- `act_valid`  out  1  registered activation strobe to the MAC array.
- `vec_count`  out  8  activations accepted since the last LOAD entry.
- `state`  out  2  current FSM state: IDLE=0, LOAD=1, RUN=2.
- `timeout_err`  out  1  sticky load-abort flag.

## Operation
- Accept condition: `acc = ena & in_valid`.
- IDLE:
  - `ena & load_req` moves to LOAD and clears `count`.
  - All other inputs are ignored.
- LOAD:
  - `load_we = acc` (combinational).
  - Each `acc` increments `count`.
  - When `acc` occurs with `count == 2^COUNT_BITS-1`:
    - `count` wraps to 0.
    - `load_done` is registered high for one cycle.
    - The FSM moves to RUN.
  - `load_req` is ignored while in LOAD.
- RUN:
  - `weights_valid = 1`.
  - `acc & ~load_req` produces `act_valid` on the next cycle and increments `vec_count`. `vec_count` saturates at 255.
  - `ena & load_req` moves to LOAD, clears `count` and `vec_count`, and drops `weights_valid` on the same edge.
  - If `load_req` and `in_valid` are both high, `load_req` wins: no `act_valid` is produced and no slice is written that cycle.
- `load_we` is 0 in every state except LOAD.
- Entering LOAD from any state clears `timeout_err`.
- Reset mid-LOAD discards the partial load. The loader contents are stale, and `weights_valid` stays 0 until a complete load finishes.

## Timing
- Reset values: `count=0`, `state=IDLE`, `load_done=0`, `weights_valid=0`, `act_valid=0`, `vec_count=0`, `timeout_err=0`. `load_we` is combinational and therefore also 0.
- Request to first write: `load_req` sampled at edge N puts LOAD active from N+1. The first `load_we` is possible in cycle N+1.
- A full load takes 16 accepted beats.
- Last-slice timing, with the last slice accepted at edge M:
  - `load_done` and `weights_valid` are high from M+1.
  - The loader's registers are settled at M+1.
- Activation latency: 1 cycle from accepted `in_valid` to `act_valid`. `vec_count` updates on the same edge that raises `act_valid`.
- `ena` low freezes the FSM, `count` and the timeout counter. A pending `act_valid` still clears after one cycle.

## Configuration
- `LOAD_TIMEOUT_EN` defined:
  - A counter tracks consecutive LOAD cycles with `ena & ~in_valid`. It resets on every `acc`.
  - When the counter reaches `TIMEOUT`: the FSM goes to IDLE, `count` is cleared, and `timeout_err` is set.
- `LOAD_TIMEOUT_EN` undefined:
  - The timeout counter is not instantiated.
  - LOAD waits indefinitely.
  - `timeout_err` is tied to 0.

## Structure
- Shared package `tt_um_pkg` holds:
  - the state enum type (IDLE/LOAD/RUN);
  - `COUNT_BITS` derivation;
  - the default `MAX_IN_LEN`/`MAX_OUT_LEN`/`WIDTH` constants, which the loader also uses.
- One natural sub-module, `tt_um_idle_timer`: the resettable saturating timeout counter. It is instantiated only under `LOAD_TIMEOUT_EN`.

## Test plan
- Reset then hold `load_req=1` for 1 cycle, then 16 `in_valid` beats -> `count` runs 0..15, `load_we` pulses 16 times, `load_done` pulses once, `state=2`, `count=0`.
- Load with `in_valid` toggling every other cycle (32 cycles) -> `count` advances only on valid beats; `load_done` follows the 16th accepted beat.
- In RUN, 3 `in_valid` beats -> 3 `act_valid` pulses each 1 cycle late, `vec_count=3`. Then 300 more beats -> `vec_count=255`.
- In RUN, `load_req` and `in_valid` high in the same cycle -> no `act_valid`, `state=1`, `weights_valid=0`, `vec_count=0`.
- Assert `rst_n=0` asynchronously after slice 7 -> all outputs 0 immediately, `state=IDLE`. A subsequent load starts at `count=0`.
- With `LOAD_TIMEOUT_EN`: enter LOAD, 5 beats, then 255 idle cycles -> `state=IDLE`, `timeout_err=1`. The next `load_req` clears it.

Source files
------------

// File: rtl/tt_um_pkg.sv
// rtl/tt_um_pkg.sv - shared state type and sizing constants for the weight loader tile
package tt_um_pkg;

  localparam int PKG_MAX_IN_LEN  = 16;
  localparam int PKG_MAX_OUT_LEN = 8;
  localparam int PKG_WIDTH       = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  function automatic int count_bits(input int out_len, input int width);
    return $clog2(out_len) + $clog2(width);
  endfunction

  localparam int PKG_COUNT_BITS = count_bits(PKG_MAX_OUT_LEN, PKG_WIDTH);

endpackage

// File: rtl/tt_um_idle_timer.sv
// rtl/tt_um_idle_timer.sv - resettable saturating idle counter; hit fires on the edge it reaches LIMIT
module tt_um_idle_timer #(
  parameter int LIMIT = 255,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  logic [W-1:0] cnt;

  // Flagged combinationally so the controller can leave LOAD on the same edge the count reaches LIMIT.
  assign hit = inc && (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != W'(LIMIT))) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/tt_um_load_ctrl.sv
// rtl/tt_um_load_ctrl.sv - load/run sequencer driving the weight loader slice index and MAC activation gate
// Optional LOAD_TIMEOUT_EN aborts a stalled load after TIMEOUT idle cycles.
module tt_um_load_ctrl
  import tt_um_pkg::*;
#(
  parameter int MAX_IN_LEN  = PKG_MAX_IN_LEN,
  parameter int MAX_OUT_LEN = PKG_MAX_OUT_LEN,
  parameter int WIDTH       = PKG_WIDTH,
  parameter int COUNT_BITS  = count_bits(MAX_OUT_LEN, WIDTH),
  parameter int TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  load_req,
  input  logic                  in_valid,
  output logic [COUNT_BITS-1:0] count,
  output logic                  load_we,
  output logic                  load_done,
  output logic                  weights_valid,
  output logic                  act_valid,
  output logic [7:0]            vec_count,
  output logic [1:0]            state,
  output logic                  timeout_err
);

  state_t st;
  logic   acc;
  logic   in_load;
  logic   timeout_hit;

  logic [31:0] unused_params;
  assign unused_params = MAX_IN_LEN ^ MAX_OUT_LEN ^ WIDTH ^ TIMEOUT;

  assign acc     = ena & in_valid;
  assign in_load = (st == ST_LOAD);
  assign load_we = in_load & acc;
  assign state   = st;

`ifdef LOAD_TIMEOUT_EN
  tt_um_idle_timer #(
    .LIMIT (TIMEOUT)
  ) u_idle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (~in_load | acc),
    .inc   (in_load & ena & ~in_valid),
    .hit   (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st            <= ST_IDLE;
      count         <= '0;
      load_done     <= 1'b0;
      weights_valid <= 1'b0;
      act_valid     <= 1'b0;
      vec_count     <= '0;
      timeout_err   <= 1'b0;
    end else begin
      load_done <= 1'b0;
      act_valid <= 1'b0;
      if (ena) begin
        case (st)
          ST_IDLE: begin
            if (load_req) begin
              st          <= ST_LOAD;
              count       <= '0;
              vec_count   <= '0;
              timeout_err <= 1'b0;
            end
          end
          ST_LOAD: begin
            if (acc) begin
              count <= count + COUNT_BITS'(1);
              if (count == {COUNT_BITS{1'b1}}) begin
                load_done     <= 1'b1;
                weights_valid <= 1'b1;
                st            <= ST_RUN;
              end
            end else if (timeout_hit) begin
              st          <= ST_IDLE;
              count       <= '0;
              timeout_err <= 1'b1;
            end
          end
          ST_RUN: begin
            // A reload request outranks a coincident activation beat.
            if (load_req) begin
              st            <= ST_LOAD;
              count         <= '0;
              vec_count     <= '0;
              weights_valid <= 1'b0;
              timeout_err   <= 1'b0;
            end else if (in_valid) begin
              act_valid <= 1'b1;
              if (vec_count != 8'hFF) vec_count <= vec_count + 8'd1;
            end
          end
          default: st <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
